// File: rtl/exe_stage_mc_if.sv
// exe_stage_mc_if: bundle of the ID/EX-side and EX/MEM-side signals of the
// execute stage. The stage itself uses the slave modport. The driver, which is
// the decode/memory environment or a testbench, uses the master modport.
interface exe_stage_mc_if #(
    parameter int DATA_W  = 8,
    parameter int PC_SIZE = 10,
    parameter int IMM_W   = 12
);
    // Upstream handshake and instruction fields
    logic               in_valid;
    logic               in_ready;
    logic [PC_SIZE-1:0] pc_in;
    logic [DATA_W-1:0]  data1;
    logic [DATA_W-1:0]  data2;
    logic [IMM_W-1:0]   immediate;
    logic [9:0]         funct;
    logic [1:0]         alu_op;
    logic               alu_src;
    logic               branch_in;
    logic               mem_read_in;
    logic               mem_to_reg_in;
    logic               mem_write_in;
    logic               reg_write_in;
    logic               flush;

    // Downstream handshake and EX/MEM register contents
    logic               out_valid;
    logic               out_ready;
    logic [PC_SIZE-1:0] pc_jump;
    logic [DATA_W-1:0]  alu_result;
    logic               zero;
    logic               branch_taken;
    logic [DATA_W-1:0]  store_data;
    logic               branch_out;
    logic               mem_read_out;
    logic               mem_to_reg_out;
    logic               mem_write_out;
    logic               reg_write_out;
    logic               busy;

    modport master (
        output in_valid, pc_in, data1, data2, immediate, funct, alu_op, alu_src,
               branch_in, mem_read_in, mem_to_reg_in, mem_write_in, reg_write_in,
               flush, out_ready,
        input  in_ready, out_valid, pc_jump, alu_result, zero, branch_taken,
               store_data, branch_out, mem_read_out, mem_to_reg_out,
               mem_write_out, reg_write_out, busy
    );

    modport slave (
        input  in_valid, pc_in, data1, data2, immediate, funct, alu_op, alu_src,
               branch_in, mem_read_in, mem_to_reg_in, mem_write_in, reg_write_in,
               flush, out_ready,
        output in_ready, out_valid, pc_jump, alu_result, zero, branch_taken,
               store_data, branch_out, mem_read_out, mem_to_reg_out,
               mem_write_out, reg_write_out, busy
    );
endinterface

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: registered RISC-V execute stage with a valid/ready handshake on
// both sides, a decoded ALU, branch-target generation and the EX/MEM register.
// Optional feature macro: EXE_MUL_EN builds the iterative shift-add multiplier
// (one partial product per cycle, DATA_W cycles per MUL). When the macro is
// undefined, MUL decodes as an unknown code and busy is tied low.
module exe_stage_mc #(
    parameter int DATA_W  = 8,
    parameter int PC_SIZE = 10,
    parameter int IMM_W   = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    exe_stage_mc_if.slave bus
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int MAX_DP = (DATA_W > PC_SIZE) ? DATA_W : PC_SIZE;
    localparam int EXT_W = (IMM_W > MAX_DP) ? IMM_W : MAX_DP;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [6:0]         funct7;
    logic [2:0]         funct3;
    logic [EXT_W-1:0]   imm_ext;
    logic               unused_imm_bits;
    logic [DATA_W-1:0]  imm_data;
    logic [PC_SIZE-1:0] imm_pc;
    logic [PC_SIZE-1:0] target_pc;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [SH_W-1:0]    shamt;
    logic [DATA_W-1:0]  alu_value;
    logic [4:0]         ctrl_in;

    logic               out_free;
    logic               accept;
    logic               single_load;
    logic               mul_done;
    logic               load;
    logic [DATA_W-1:0]  load_result;
    logic [DATA_W-1:0]  load_store;
    logic [PC_SIZE-1:0] load_pc;
    logic [4:0]         load_ctrl;

    logic               out_valid_reg;
    logic [DATA_W-1:0]  result_reg;
    logic               zero_reg;
    logic [PC_SIZE-1:0] pc_jump_reg;
    logic [DATA_W-1:0]  store_reg;
    logic [4:0]         ctrl_reg;

    assign funct7 = bus.funct[9:3];
    assign funct3 = bus.funct[2:0];

    // Sign-extend the immediate once to the widest datapath, then take low bits
    // for the ALU and the PC adder. This also truncates when IMM_W is wider.
    assign imm_ext         = EXT_W'($signed(bus.immediate));
    assign unused_imm_bits = ^imm_ext;
    assign imm_data        = imm_ext[DATA_W-1:0];
    assign imm_pc          = imm_ext[PC_SIZE-1:0];
    assign target_pc       = bus.pc_in + imm_pc;

    assign op_a  = bus.data1;
    assign op_b  = bus.alu_src ? imm_data : bus.data2;
    assign shamt = op_b[SH_W-1:0];

    assign ctrl_in = {bus.branch_in, bus.mem_read_in, bus.mem_to_reg_in,
                      bus.mem_write_in, bus.reg_write_in};

    // Single-cycle ALU. A MUL code yields 0 here because the product comes
    // from the iterative unit instead.
    always_comb begin
        alu_value = '0;
        case (bus.alu_op)
            2'b00: alu_value = op_a + op_b;
            2'b01: alu_value = op_a - op_b;
            2'b11: alu_value = bus.data2;
            default: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            alu_value = op_a + op_b;
                        end else if (funct7 == 7'b0100000) begin
                            alu_value = op_a - op_b;
                        end
                    end
                    3'b001: alu_value = op_a << shamt;
                    3'b010: alu_value = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                    3'b011: alu_value = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
                    3'b100: alu_value = op_a ^ op_b;
                    3'b101: begin
                        if (funct7 == 7'b0000000) begin
                            alu_value = op_a >> shamt;
                        end else if (funct7 == 7'b0100000) begin
                            alu_value = $signed(op_a) >>> shamt;
                        end
                    end
                    3'b110: alu_value = op_a | op_b;
                    default: alu_value = op_a & op_b;
                endcase
            end
        endcase
    end

    // Handshake: the register can take new data when empty or being drained.
    // Flush blocks acceptance so an instruction presented with it is dropped.
    assign out_free     = !out_valid_reg || bus.out_ready;
    assign bus.in_ready = !bus.flush && (state_reg == IDLE) && out_free;
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef EXE_MUL_EN
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic               is_mul;
    logic               mul_start;
    logic               mul_step;
    logic [DATA_W-1:0]  mcand_reg;
    logic [DATA_W-1:0]  mplier_reg;
    logic [DATA_W-1:0]  acc_reg;
    logic [DATA_W-1:0]  acc_step;
    logic [CNT_W-1:0]   cnt_reg;
    logic [PC_SIZE-1:0] pend_pc_reg;
    logic [DATA_W-1:0]  pend_store_reg;
    logic [4:0]         pend_ctrl_reg;

    assign is_mul    = (bus.alu_op == 2'b10) && (bus.funct == {7'b0000001, 3'b000});
    assign mul_start = accept && is_mul;
    assign acc_step  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    // The last partial product is folded in on the cycle the result loads.
    // If the output is stalled, the counter stays at its last value and the
    // sum is recomputed identically each cycle until the register frees.
    assign mul_step  = (state_reg == MUL) && (cnt_reg != CNT_LAST) && !bus.flush;
    assign mul_done  = (state_reg == MUL) && (cnt_reg == CNT_LAST) && out_free && !bus.flush;
    assign bus.busy  = (state_reg == MUL);

    // Multiplier datapath: latch operands and payload at acceptance, then shift-add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg      <= '0;
            mplier_reg     <= '0;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            pend_pc_reg    <= '0;
            pend_store_reg <= '0;
            pend_ctrl_reg  <= '0;
        end else if (bus.flush) begin
            cnt_reg <= '0;
        end else if (mul_start) begin
            mcand_reg      <= op_a;
            mplier_reg     <= op_b;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            pend_pc_reg    <= target_pc;
            pend_store_reg <= bus.data2;
            pend_ctrl_reg  <= ctrl_in;
        end else if (mul_step) begin
            acc_reg    <= acc_step;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CNT_W'(1);
        end else if (mul_done) begin
            cnt_reg <= '0;
        end
    end

    // Select what the output register captures: the finished product or the
    // single-cycle result of the instruction being accepted now.
    always_comb begin
        load_result = alu_value;
        load_store  = bus.data2;
        load_pc     = target_pc;
        load_ctrl   = ctrl_in;
        if (mul_done) begin
            load_result = acc_step;
            load_store  = pend_store_reg;
            load_pc     = pend_pc_reg;
            load_ctrl   = pend_ctrl_reg;
        end
    end

    // Next-state logic: flush always returns to IDLE.
    always_comb begin
        state_next = state_reg;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (mul_start) state_next = MUL;
                default: if (mul_done)  state_next = IDLE;
            endcase
        end
    end

    assign single_load = accept && !is_mul;
`else
    assign mul_done    = 1'b0;
    assign bus.busy    = 1'b0;
    assign single_load = accept;

    // Without the multiplier, every accepted instruction loads directly.
    always_comb begin
        load_result = alu_value;
        load_store  = bus.data2;
        load_pc     = target_pc;
        load_ctrl   = ctrl_in;
    end

    // Without the multiplier, the FSM never leaves IDLE.
    always_comb begin
        state_next = IDLE;
    end
`endif

    assign load = single_load || mul_done;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // EX/MEM register. Flush wins over everything, then loading, then draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            pc_jump_reg   <= '0;
            store_reg     <= '0;
            ctrl_reg      <= '0;
        end else if (bus.flush) begin
            out_valid_reg <= 1'b0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            result_reg    <= load_result;
            zero_reg      <= (load_result == '0);
            pc_jump_reg   <= load_pc;
            store_reg     <= load_store;
            ctrl_reg      <= load_ctrl;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid      = out_valid_reg;
    assign bus.alu_result     = result_reg;
    assign bus.zero           = zero_reg;
    assign bus.pc_jump        = pc_jump_reg;
    assign bus.store_data     = store_reg;
    assign bus.branch_out     = ctrl_reg[4];
    assign bus.mem_read_out   = ctrl_reg[3];
    assign bus.mem_to_reg_out = ctrl_reg[2];
    assign bus.mem_write_out  = ctrl_reg[1];
    assign bus.reg_write_out  = ctrl_reg[0];
    assign bus.branch_taken   = ctrl_reg[4] & zero_reg;
endmodule

// File: tb/tb_exe_stage_mc.sv
// tb_exe_stage_mc: directed self-checking bench for exe_stage_mc (DATA_W=8,
// PC_SIZE=10, IMM_W=12). Expectations follow the EXE_MUL_EN setting of the build.
module tb_exe_stage_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    exe_stage_mc_if #(.DATA_W(8), .PC_SIZE(10), .IMM_W(12)) bus ();

    exe_stage_mc #(.DATA_W(8), .PC_SIZE(10), .IMM_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] F_ADD  = {7'b0000000, 3'b000};
    localparam logic [9:0] F_SUB  = {7'b0100000, 3'b000};
    localparam logic [9:0] F_SLL  = {7'b0000000, 3'b001};
    localparam logic [9:0] F_SLT  = {7'b0000000, 3'b010};
    localparam logic [9:0] F_SLTU = {7'b0000000, 3'b011};
    localparam logic [9:0] F_XOR  = {7'b0000000, 3'b100};
    localparam logic [9:0] F_SRL  = {7'b0000000, 3'b101};
    localparam logic [9:0] F_SRA  = {7'b0100000, 3'b101};
    localparam logic [9:0] F_OR   = {7'b0000000, 3'b110};
    localparam logic [9:0] F_AND  = {7'b0000000, 3'b111};
    localparam logic [9:0] F_MUL  = {7'b0000001, 3'b000};
    localparam logic [9:0] F_BAD  = {7'b0000001, 3'b101};

    typedef struct packed {
        logic [1:0]  op;
        logic [9:0]  fn;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        src;
        logic [11:0] imm;
        logic [7:0]  exp;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] op, input logic [9:0] fn,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic src, input logic [11:0] imm,
                           input logic [9:0] pc, input logic br);
        bus.in_valid      = 1'b1;
        bus.alu_op        = op;
        bus.funct         = fn;
        bus.data1         = a;
        bus.data2         = b;
        bus.alu_src       = src;
        bus.immediate     = imm;
        bus.pc_in         = pc;
        bus.branch_in     = br;
        bus.reg_write_in  = !br;
        bus.mem_read_in   = 1'b0;
        bus.mem_to_reg_in = 1'b0;
        bus.mem_write_in  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.alu_op = 2'b00; bus.funct = '0; bus.data1 = '0;
        bus.data2 = '0; bus.alu_src = 1'b0; bus.immediate = '0; bus.pc_in = '0;
        bus.branch_in = 1'b0; bus.mem_read_in = 1'b0; bus.mem_to_reg_in = 1'b0;
        bus.mem_write_in = 1'b0; bus.reg_write_in = 1'b0; bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.alu_result !== 8'h00) begin errors++; $display("FAIL reset_alu_result: got %h expected 00", bus.alu_result); end
        checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", bus.zero); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.pc_jump !== 10'h000) begin errors++; $display("FAIL reset_pc_jump: got %h expected 000", bus.pc_jump); end
        checks++; if (bus.branch_taken !== 1'b0) begin errors++; $display("FAIL reset_branch_taken: got %b expected 0", bus.branch_taken); end
        rst_n = 1'b1;
        step();
        $display("txn reset released");
    endtask

    task automatic test_add();
        present(2'b10, F_ADD, 8'h05, 8'h03, 1'b0, 12'h000, 10'h000, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b expected 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.alu_result !== 8'h08) begin errors++; $display("FAIL add_result: got %h expected 08", bus.alu_result); end
        checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL add_zero: got %b expected 0", bus.zero); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.reg_write_out !== 1'b1) begin errors++; $display("FAIL add_reg_write: got %b expected 1", bus.reg_write_out); end
        checks++; if (bus.store_data !== 8'h03) begin errors++; $display("FAIL add_store_data: got %h expected 03", bus.store_data); end
        $display("txn add 05+03 -> %h", bus.alu_result);
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_branch();
        present(2'b01, F_ADD, 8'h3C, 8'h3C, 1'b0, 12'hFF8, 10'h010, 1'b1);
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL beq_zero: got %b expected 1", bus.zero); end
        checks++; if (bus.branch_taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b expected 1", bus.branch_taken); end
        checks++; if (bus.pc_jump !== 10'h008) begin errors++; $display("FAIL beq_pc_jump: got %h expected 008", bus.pc_jump); end
        checks++; if (bus.alu_result !== 8'h00) begin errors++; $display("FAIL beq_result: got %h expected 00", bus.alu_result); end
        checks++; if (bus.reg_write_out !== 1'b0) begin errors++; $display("FAIL beq_reg_write: got %b expected 0", bus.reg_write_out); end
        $display("txn beq pc=010 imm=ff8 -> pc_jump=%h taken=%b", bus.pc_jump, bus.branch_taken);
        step();
    endtask

    task automatic test_back_to_back();
        vec_t vecs [15];
        vecs = '{
            '{2'b10, F_SRA,  8'h90, 8'h02, 1'b0, 12'h000, 8'hE4},
            '{2'b10, F_SLT,  8'h80, 8'h01, 1'b0, 12'h000, 8'h01},
            '{2'b10, F_SLTU, 8'h80, 8'h01, 1'b0, 12'h000, 8'h00},
            '{2'b10, F_SUB,  8'h05, 8'h07, 1'b0, 12'h000, 8'hFE},
            '{2'b10, F_XOR,  8'hF0, 8'h3C, 1'b0, 12'h000, 8'hCC},
            '{2'b10, F_OR,   8'h50, 8'h0A, 1'b0, 12'h000, 8'h5A},
            '{2'b10, F_AND,  8'hF0, 8'h3C, 1'b0, 12'h000, 8'h30},
            '{2'b10, F_SRL,  8'h90, 8'h02, 1'b0, 12'h000, 8'h24},
            '{2'b10, F_SLL,  8'h11, 8'hAA, 1'b1, 12'h003, 8'h88},
            '{2'b10, F_BAD,  8'h12, 8'h34, 1'b0, 12'h000, 8'h00},
            '{2'b00, F_ADD,  8'hFF, 8'h02, 1'b0, 12'h000, 8'h01},
            '{2'b11, F_ADD,  8'h12, 8'h77, 1'b0, 12'h000, 8'h77},
            '{2'b00, F_ADD,  8'h10, 8'h55, 1'b1, 12'hFFE, 8'h0E},
            '{2'b10, F_SLL,  8'h01, 8'h09, 1'b0, 12'h000, 8'h02},
            '{2'b01, F_ADD,  8'h00, 8'h01, 1'b0, 12'h000, 8'hFF}
        };
        for (int i = 0; i < 15; i++) begin
            present(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].src, vecs[i].imm, 10'h000, 1'b0);
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
            step();
            checks++; if (bus.alu_result !== vecs[i].exp) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, bus.alu_result, vecs[i].exp); end
            checks++; if (bus.zero !== (vecs[i].exp == 8'h00)) begin errors++; $display("FAIL b2b_zero[%0d]: got %b expected %b", i, bus.zero, (vecs[i].exp == 8'h00)); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            $display("txn op=%b funct=%b a=%h b=%h -> %h", vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, bus.alu_result);
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_mul();
        present(2'b10, F_MUL, 8'h0D, 8'h0B, 1'b0, 12'h000, 10'h000, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mul_accept_ready: got %b expected 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        bus.data1 = 8'hFF;
        bus.data2 = 8'hFF;
`ifdef EXE_MUL_EN
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mul_busy[%0d]: got %b expected 1", i, bus.busy); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mul_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mul_early_valid[%0d]: got %b expected 0", i, bus.out_valid); end
            step();
        end
        checks++; if (bus.alu_result !== 8'h8F) begin errors++; $display("FAIL mul_result: got %h expected 8f", bus.alu_result); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_busy_end: got %b expected 0", bus.busy); end
        checks++; if (bus.store_data !== 8'h0B) begin errors++; $display("FAIL mul_store_data: got %h expected 0b", bus.store_data); end
`else
        checks++; if (bus.alu_result !== 8'h00) begin errors++; $display("FAIL mul_result: got %h expected 00", bus.alu_result); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL mul_zero: got %b expected 1", bus.zero); end
`endif
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mul_out_valid: got %b expected 1", bus.out_valid); end
        $display("txn mul 0d*0b -> %h", bus.alu_result);
        step();
    endtask

    task automatic test_stall();
        present(2'b10, F_ADD, 8'h20, 8'h01, 1'b0, 12'h000, 10'h000, 1'b0);
        step();
        bus.out_ready = 1'b0;
        present(2'b10, F_ADD, 8'h30, 8'h04, 1'b0, 12'h000, 10'h000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            checks++; if (bus.alu_result !== 8'h21) begin errors++; $display("FAIL stall_result[%0d]: got %h expected 21", i, bus.alu_result); end
            checks++; if (bus.store_data !== 8'h01) begin errors++; $display("FAIL stall_store[%0d]: got %h expected 01", i, bus.store_data); end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.alu_result !== 8'h34) begin errors++; $display("FAIL release_result: got %h expected 34", bus.alu_result); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL release_out_valid: got %b expected 1", bus.out_valid); end
        $display("txn stall released -> %h", bus.alu_result);
        step();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        present(2'b10, F_ADD, 8'h01, 8'h01, 1'b0, 12'h000, 10'h000, 1'b0);
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b expected 1", bus.out_valid); end
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        present(2'b10, F_ADD, 8'h02, 8'h02, 1'b0, 12'h000, 10'h000, 1'b0);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready); end
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
        $display("txn flush of output register");
`ifdef EXE_MUL_EN
        present(2'b10, F_MUL, 8'h03, 8'h05, 1'b0, 12'h000, 10'h000, 1'b0);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL flush_mul_busy_before: got %b expected 1", bus.busy); end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_mul_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_mul_out_valid: got %b expected 0", bus.out_valid); end
        $display("txn flush during mul");
`endif
        present(2'b10, F_ADD, 8'h06, 8'h07, 1'b0, 12'h000, 10'h000, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_flush_ready: got %b expected 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.alu_result !== 8'h0D) begin errors++; $display("FAIL post_flush_result: got %h expected 0d", bus.alu_result); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL post_flush_valid: got %b expected 1", bus.out_valid); end
        $display("txn add after flush -> %h", bus.alu_result);
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_flush_ghost[%0d]: got %b expected 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_async_reset();
`ifdef EXE_MUL_EN
        present(2'b10, F_MUL, 8'h0D, 8'h0B, 1'b0, 12'h000, 10'h000, 1'b0);
        step();
        bus.in_valid = 1'b0;
        step();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy: got %b expected 1", bus.busy); end
`else
        present(2'b10, F_ADD, 8'h01, 8'h02, 1'b0, 12'h000, 10'h000, 1'b0);
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b expected 1", bus.out_valid); end
`endif
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.alu_result !== 8'h00) begin errors++; $display("FAIL areset_result: got %h expected 00", bus.alu_result); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready: got %b expected 1", bus.in_ready); end
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_after: got %b expected 0", bus.out_valid); end
        $display("txn async reset mid-operation");
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_back_to_back();
        test_mul();
        test_stall();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/exe_stage_mc.md
# exe_stage_mc

Parametrised execute stage for the RISC-V pipeline. It replaces the purely combinational execute logic with a registered EX/MEM boundary, a valid/ready handshake on both sides, a widened ALU, branch-target generation and an optional iterative multiplier. It sits between the ID/EX register and the memory stage and owns the EX/MEM pipeline register.

## Interface
Parameters:
- `DATA_W`, 8: operand and result width, ≥ 4.
- `PC_SIZE`, 10: program-counter width.
- `IMM_W`, 12: immediate width; sign-extended to `DATA_W` and to `PC_SIZE`.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: an instruction is presented.
- `in_ready`  out  1: the stage accepts the instruction this cycle.
- `pc_in`  in  PC_SIZE: PC of the instruction.
- `data1`, `data2`  in  DATA_W: register operands.
- `immediate`  in  IMM_W: raw immediate.
- `funct`  in  10: {funct7, funct3}.
- `alu_op`  in  2: 00 add, 01 sub, 10 decode `funct`, 11 pass `data2`.
- `alu_src`  in  1: 1 selects the sign-extended immediate as operand B.
- `branch_in`, `mem_read_in`, `mem_to_reg_in`, `mem_write_in`, `reg_write_in`  in  1 each: control bits.
- `flush`  in  1: kill the in-flight and output-register contents.
- `out_valid`  out  1: the EX/MEM register holds a valid instruction.
- `out_ready`  in  1: the memory stage accepts the output.
- `pc_jump`  out  PC_SIZE: `pc_in + sext(immediate)`, mod 2^PC_SIZE.
- `alu_result`  out  DATA_W: registered result.
- `zero`  out  1: `alu_result == 0`.
- `branch_taken`  out  1: `branch & zero`.
- `store_data`  out  DATA_W: registered `data2`.
- `branch_out`, `mem_read_out`, `mem_to_reg_out`, `mem_write_out`, `reg_write_out`  out  1 each: registered control bits.
- `busy`  out  1: a multiply is in progress.

## Operation
Decode for `alu_op` = 10, keyed on funct7/funct3:
- 0000000/000 ADD; 0100000/000 SUB.
- 111 AND; 110 OR; 100 XOR.
- 001 SLL; 0000000/101 SRL; 0100000/101 SRA. Shift amount is `B[$clog2(DATA_W)-1:0]`.
- 010 SLT (signed, result 1 or 0); 011 SLTU.
- 0000001/000 MUL: low `DATA_W` bits of the product; multi-cycle, see Configuration.
- Any other code produces result 0.

Arithmetic rules:
- All arithmetic wraps modulo 2^DATA_W.
- The immediate is sign-extended from bit IMM_W-1 before the `alu_src` mux.
- If `IMM_W` > `DATA_W`, the immediate is truncated.

State machine `IDLE` / `MUL`:
- IDLE → MUL on an accepted MUL instruction.
- MUL → IDLE when the iteration counter reaches `DATA_W`-1 and the result is loaded into the output register.

Output register:
- Loads when an instruction completes and (`!out_valid || out_ready`).
- Clears `out_valid` when `out_ready` is high and nothing new loads.

## Timing
- Reset: all outputs 0; `in_ready` = 1; state IDLE; counter 0.
- Single-cycle ops have latency 1: accepted at edge N, `out_valid` and result visible after edge N.
- `in_ready` = `!busy && (!out_valid || out_ready)`. Back-to-back single-cycle ops sustain 1 per cycle while `out_ready` = 1.
- MUL takes `DATA_W` cycles, one shift-add per cycle.
  - `busy` = 1 from the edge after acceptance until the result loads.
  - `in_ready` = 0 throughout.
  - Operands are latched at acceptance; later changes on `data1`/`data2` are ignored.
- If the MUL finishes while the output is stalled (`out_valid && !out_ready`), it holds in MUL with the counter saturated until the register frees.
- `flush`:
  - Synchronous, and takes priority over every other event.
  - The next edge clears `out_valid` and returns the FSM to IDLE.
  - An instruction presented in the same cycle is dropped, and `in_ready` is forced to 0 during `flush`.
- Outputs hold their values while `out_valid && !out_ready`.
- `rst_n` low mid-multiply aborts immediately to the reset values.

## Configuration
- `EXE_MUL_EN` defined: the iterative multiplier, `busy` logic and MUL state are built.
- Undefined:
  - The MUL code decodes as unknown (result 0) and completes in 1 cycle.
  - `busy` is tied to 0.
  - The FSM stays in IDLE.

## Test plan
- Reset, then ADD `data1`=0x05 `data2`=0x03 `alu_op`=10 → one edge later `alu_result`=0x08, `zero`=0, `out_valid`=1.
- BEQ: `alu_op`=01, `data1`=`data2`=0x3C, `branch_in`=1, `pc_in`=0x010, `immediate`=0xFF8 → `zero`=1, `branch_taken`=1, `pc_jump`=0x008.
- SRA `data1`=0x90 by 2 → 0xE4; SLT 0x80 vs 0x01 → 1; SLTU 0x80 vs 0x01 → 0.
- With `EXE_MUL_EN`, MUL 0x0D×0x0B (`DATA_W`=8) → `in_ready`=0 for 8 cycles, then `alu_result`=0x8F. Without the macro → 0x00 after 1 cycle.
- Hold `out_ready`=0 for 3 cycles with a valid output → outputs stable, `in_ready`=0; on release, the next queued ADD loads on the following edge.
- Assert `flush` during a MUL at cycle 3 → `out_valid`=0, `busy`=0 on the next edge; a new ADD is then accepted normally.
